// File: rtl/ctrl_pkg.sv
// Shared constants and types for the control-step sequencer: opcodes, step
// encoding, ALU selects and the control word produced each step.
package ctrl_pkg;

   localparam int unsigned OP_W   = 5;
   localparam int unsigned STEP_W = 4;
   localparam int unsigned ALU_W  = 4;

   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
   localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
   localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
   localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;

   typedef enum logic [STEP_W-1:0] {
      ST_T0   = 4'd0,
      ST_T1   = 4'd1,
      ST_T2   = 4'd2,
      ST_T3   = 4'd3,
      ST_T4   = 4'd4,
      ST_T5   = 4'd5,
      ST_T6   = 4'd6,
      ST_T7   = 4'd7,
      ST_HALT = 4'd15
   } step_e;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_R,
      CLS_I,
      CLS_LD,
      CLS_ST,
      CLS_HALT
   } op_class_e;

   typedef struct packed {
      logic             gra;
      logic             grb;
      logic             grc;
      logic             r_in_enable;
      logic             r_out_enable;
      logic             ba_out;
      logic             pc_out;
      logic             pc_in;
      logic             inc_pc;
      logic             mar_in;
      logic             mdr_in;
      logic             mdr_out;
      logic             ir_in;
      logic             y_in;
      logic             z_in;
      logic             zlow_out;
      logic             c_out;
      logic             read;
      logic             write;
      logic [ALU_W-1:0] alu_op;
      logic             halted;
   } ctrl_word_t;

   // Unlisted opcodes fall into CLS_NOP.
   function automatic op_class_e op_class(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_R;
         OP_ADDI, OP_ANDI, OP_ORI:      return CLS_I;
         OP_LD:                         return CLS_LD;
         OP_ST:                         return CLS_ST;
         OP_HALT:                       return CLS_HALT;
         OP_NOP:                        return CLS_NOP;
         default:                       return CLS_NOP;
      endcase
   endfunction

   function automatic logic [ALU_W-1:0] alu_sel(input logic [OP_W-1:0] op);
      case (op)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR, OP_ORI:   return ALU_OR;
         default:         return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: opcode/memory status in, select and strobe
// lines out. master = sequencer side, slave = datapath side.
interface control_sequencer_if;
   import ctrl_pkg::*;

   logic [OP_W-1:0]   ir_op;
   logic              mem_done;
   logic              Gra, Grb, Grc;
   logic              r_in_enable, r_out_enable, BA_out;
   logic              PC_out, PC_in, inc_pc, MAR_in, MDR_in, MDR_out;
   logic              IR_in, Y_in, Z_in, Zlow_out, C_out;
   logic              read, write;
   logic [ALU_W-1:0]  alu_op;
   logic [STEP_W-1:0] step;
   logic              halted;

   modport master (
      input  ir_op, mem_done,
      output Gra, Grb, Grc, r_in_enable, r_out_enable, BA_out,
             PC_out, PC_in, inc_pc, MAR_in, MDR_in, MDR_out,
             IR_in, Y_in, Z_in, Zlow_out, C_out,
             read, write, alu_op, step, halted
   );

   modport slave (
      output ir_op, mem_done,
      input  Gra, Grb, Grc, r_in_enable, r_out_enable, BA_out,
             PC_out, PC_in, inc_pc, MAR_in, MDR_in, MDR_out,
             IR_in, Y_in, Z_in, Zlow_out, C_out,
             read, write, alu_op, step, halted
   );

endinterface

// File: rtl/ctrl_step_decode.sv
// Moore control-word decode: current step plus opcode -> select/strobe set.
module ctrl_step_decode
   import ctrl_pkg::*;
(
   input  step_e           step,
   input  logic [OP_W-1:0] ir_op,
   output ctrl_word_t      cw_c
);

   op_class_e cls;

   always_comb begin
      cw_c = '0;
      cls  = op_class(ir_op);
      case (step)
         ST_T0: begin
            cw_c.pc_out = 1'b1;
            cw_c.mar_in = 1'b1;
            cw_c.inc_pc = 1'b1;
            cw_c.z_in   = 1'b1;
            cw_c.alu_op = ALU_ADD;
         end
         ST_T1: begin
            cw_c.zlow_out = 1'b1;
            cw_c.pc_in    = 1'b1;
            cw_c.read     = 1'b1;
            cw_c.mdr_in   = 1'b1;
         end
         ST_T2: begin
            cw_c.mdr_out = 1'b1;
            cw_c.ir_in   = 1'b1;
         end
         ST_T3: begin
            case (cls)
               CLS_R, CLS_I: begin
                  cw_c.grb          = 1'b1;
                  cw_c.r_out_enable = 1'b1;
                  cw_c.y_in         = 1'b1;
               end
               // Base register is read through BA_out so R0 reads as zero.
               CLS_LD, CLS_ST: begin
                  cw_c.grb    = 1'b1;
                  cw_c.ba_out = 1'b1;
                  cw_c.y_in   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            case (cls)
               CLS_R: begin
                  cw_c.grc          = 1'b1;
                  cw_c.r_out_enable = 1'b1;
                  cw_c.z_in         = 1'b1;
                  cw_c.alu_op       = alu_sel(ir_op);
               end
               CLS_I: begin
                  cw_c.c_out  = 1'b1;
                  cw_c.z_in   = 1'b1;
                  cw_c.alu_op = alu_sel(ir_op);
               end
               CLS_LD, CLS_ST: begin
                  cw_c.c_out  = 1'b1;
                  cw_c.z_in   = 1'b1;
                  cw_c.alu_op = ALU_ADD;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (cls)
               CLS_R, CLS_I: begin
                  cw_c.zlow_out    = 1'b1;
                  cw_c.gra         = 1'b1;
                  cw_c.r_in_enable = 1'b1;
               end
               CLS_LD, CLS_ST: begin
                  cw_c.zlow_out = 1'b1;
                  cw_c.mar_in   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            case (cls)
               CLS_LD: begin
                  cw_c.read   = 1'b1;
                  cw_c.mdr_in = 1'b1;
               end
               CLS_ST: begin
                  cw_c.gra          = 1'b1;
                  cw_c.r_out_enable = 1'b1;
                  cw_c.mdr_in       = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (cls)
               CLS_LD: begin
                  cw_c.mdr_out     = 1'b1;
                  cw_c.gra         = 1'b1;
                  cw_c.r_in_enable = 1'b1;
               end
               CLS_ST:  cw_c.write = 1'b1;
               default: ;
            endcase
         end
         ST_HALT: cw_c.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Control-step sequencer: step register, memory wait handling and next-step
// logic. Define MEM_WAIT_EN to stall memory steps on mem_done.
module control_sequencer
   import ctrl_pkg::*;
(
   input logic                 clk,
   input logic                 clr,
   control_sequencer_if.master bus
);

   step_e      step_q, step_d;
   op_class_e  cls;
   logic       mem_ok;
   ctrl_word_t cw_c, cw_g;

`ifdef MEM_WAIT_EN
   assign mem_ok = bus.mem_done;
`else
   logic unused_mem_done;
   assign unused_mem_done = bus.mem_done;
   assign mem_ok          = 1'b1;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) step_q <= ST_T0;
      else     step_q <= step_d;
   end

   // Memory steps: T1 always, T6 for ld, T7 for st.
   always_comb begin
      step_d = step_q;
      cls    = op_class(bus.ir_op);
      case (step_q)
         ST_T0: step_d = ST_T1;
         ST_T1: if (mem_ok) step_d = ST_T2;
         ST_T2: step_d = ST_T3;
         ST_T3: begin
            case (cls)
               CLS_HALT: step_d = ST_HALT;
               CLS_NOP:  step_d = ST_T0;
               default:  step_d = ST_T4;
            endcase
         end
         ST_T4: step_d = ST_T5;
         ST_T5: step_d = (cls == CLS_LD || cls == CLS_ST) ? ST_T6 : ST_T0;
         ST_T6: if (cls != CLS_LD || mem_ok) step_d = ST_T7;
         ST_T7: if (cls != CLS_ST || mem_ok) step_d = ST_T0;
         ST_HALT: step_d = ST_HALT;
         default: step_d = ST_T0;
      endcase
   end

   ctrl_step_decode u_decode (
      .step  (step_q),
      .ir_op (bus.ir_op),
      .cw_c  (cw_c)
   );

   // clr silences every strobe immediately, including an in-flight read/write.
   always_comb begin
      cw_g = cw_c;
      if (clr) cw_g = '0;
   end

   assign bus.Gra          = cw_g.gra;
   assign bus.Grb          = cw_g.grb;
   assign bus.Grc          = cw_g.grc;
   assign bus.r_in_enable  = cw_g.r_in_enable;
   assign bus.r_out_enable = cw_g.r_out_enable;
   assign bus.BA_out       = cw_g.ba_out;
   assign bus.PC_out       = cw_g.pc_out;
   assign bus.PC_in        = cw_g.pc_in;
   assign bus.inc_pc       = cw_g.inc_pc;
   assign bus.MAR_in       = cw_g.mar_in;
   assign bus.MDR_in       = cw_g.mdr_in;
   assign bus.MDR_out      = cw_g.mdr_out;
   assign bus.IR_in        = cw_g.ir_in;
   assign bus.Y_in         = cw_g.y_in;
   assign bus.Z_in         = cw_g.z_in;
   assign bus.Zlow_out     = cw_g.zlow_out;
   assign bus.C_out        = cw_g.c_out;
   assign bus.read         = cw_g.read;
   assign bus.write        = cw_g.write;
   assign bus.alu_op       = cw_g.alu_op;
   assign bus.halted       = cw_g.halted;
   assign bus.step         = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; expectations follow MEM_WAIT_EN.
module tb_control_sequencer;
   import ctrl_pkg::*;

   logic clk;
   logic clr;
   int   total;
   int   bad;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [18:0] M_GRA  = 19'(1) << 18;
   localparam logic [18:0] M_GRB  = 19'(1) << 17;
   localparam logic [18:0] M_GRC  = 19'(1) << 16;
   localparam logic [18:0] M_RIN  = 19'(1) << 15;
   localparam logic [18:0] M_ROUT = 19'(1) << 14;
   localparam logic [18:0] M_BA   = 19'(1) << 13;
   localparam logic [18:0] M_PCO  = 19'(1) << 12;
   localparam logic [18:0] M_PCI  = 19'(1) << 11;
   localparam logic [18:0] M_INC  = 19'(1) << 10;
   localparam logic [18:0] M_MARI = 19'(1) << 9;
   localparam logic [18:0] M_MDRI = 19'(1) << 8;
   localparam logic [18:0] M_MDRO = 19'(1) << 7;
   localparam logic [18:0] M_IRI  = 19'(1) << 6;
   localparam logic [18:0] M_YI   = 19'(1) << 5;
   localparam logic [18:0] M_ZI   = 19'(1) << 4;
   localparam logic [18:0] M_ZLO  = 19'(1) << 3;
   localparam logic [18:0] M_CO   = 19'(1) << 2;
   localparam logic [18:0] M_RD   = 19'(1) << 1;
   localparam logic [18:0] M_WR   = 19'(1) << 0;

   localparam logic [18:0] W_T0 = M_PCO | M_MARI | M_INC | M_ZI;
   localparam logic [18:0] W_T1 = M_ZLO | M_PCI | M_RD | M_MDRI;
   localparam logic [18:0] W_T2 = M_MDRO | M_IRI;

   function automatic logic [18:0] obs();
      return {bus.Gra, bus.Grb, bus.Grc, bus.r_in_enable, bus.r_out_enable,
              bus.BA_out, bus.PC_out, bus.PC_in, bus.inc_pc, bus.MAR_in,
              bus.MDR_in, bus.MDR_out, bus.IR_in, bus.Y_in, bus.Z_in,
              bus.Zlow_out, bus.C_out, bus.read, bus.write};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus.step, bus.halted, bus.alu_op} !== 9'd0) begin
         bad++;
         $display("FAIL reset_state: got %h expected 0", {bus.step, bus.halted, bus.alu_op});
      end
      total++;
      if (obs() !== 19'd0) begin
         bad++;
         $display("FAIL reset_strobes: got %h expected 0", obs());
      end
      clr = 1'b0;
      #1;
      total++;
      if ({bus.step, obs()} !== {4'd0, W_T0}) begin
         bad++;
         $display("FAIL reset_release_t0: got %h expected %h", {bus.step, obs()}, {4'd0, W_T0});
      end
   endtask

   task automatic test_add();
      logic [3:0]  es [7];
      logic [18:0] ew [7];
      logic [26:0] got, exp_v;
      es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
      ew = '{W_T0, W_T1, W_T2, M_GRB | M_ROUT | M_YI, M_GRC | M_ROUT | M_ZI,
             M_ZLO | M_GRA | M_RIN, W_T0};
      bus.ir_op    = OP_ADD;
      bus.mem_done = 1'b1;
      for (int i = 0; i < 7; i++) begin
         got   = {bus.step, bus.alu_op, obs()};
         exp_v = {es[i], 4'd0, ew[i]};
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL add_row%0d: got %h expected %h", i, got, exp_v);
         end
         if (i < 6) tick();
      end
   endtask

   task automatic test_alu_ops();
      logic [4:0]  ops  [6];
      logic [3:0]  alus [6];
      logic [18:0] w4;
      logic [26:0] got, exp_v;
      ops  = '{OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI};
      alus = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd2, 4'd3};
      bus.mem_done = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.ir_op = ops[i];
         repeat (4) tick();
         w4    = (i >= 3) ? (M_CO | M_ZI) : (M_GRC | M_ROUT | M_ZI);
         got   = {bus.step, bus.alu_op, obs()};
         exp_v = {4'd4, alus[i], w4};
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL alu_t4_op%0d: got %h expected %h", i, got, exp_v);
         end
         tick();
         total++;
         if ({bus.step, obs()} !== {4'd5, M_ZLO | M_GRA | M_RIN}) begin
            bad++;
            $display("FAIL alu_t5_op%0d: got %h expected %h", i, {bus.step, obs()},
                     {4'd5, M_ZLO | M_GRA | M_RIN});
         end
         tick();
         total++;
         if (bus.step !== 4'd0) begin
            bad++;
            $display("FAIL alu_return_op%0d: got %0d expected 0", i, bus.step);
         end
      end
   endtask

   task automatic test_ld();
      int          n;
      logic [3:0]  es [12];
      logic        md [12];
      logic [18:0] w;
      logic [26:0] got, exp_v;
      bus.ir_op = OP_LD;
`ifdef MEM_WAIT_EN
      n  = 12;
      es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd0};
      md = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
      n  = 9;
      es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
      md = '{default: 1'b0};
`endif
      for (int i = 0; i < n; i++) begin
         bus.mem_done = md[i];
         case (es[i])
            4'd0:    w = W_T0;
            4'd1:    w = W_T1;
            4'd2:    w = W_T2;
            4'd3:    w = M_GRB | M_BA | M_YI;
            4'd4:    w = M_CO | M_ZI;
            4'd5:    w = M_ZLO | M_MARI;
            4'd6:    w = M_RD | M_MDRI;
            default: w = M_MDRO | M_GRA | M_RIN;
         endcase
         got   = {bus.step, bus.alu_op, obs()};
         exp_v = {es[i], 4'd0, w};
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL ld_row%0d: got %h expected %h", i, got, exp_v);
         end
         if (i < n - 1) tick();
      end
   endtask

   task automatic test_st();
      logic [18:0] ew [9];
      logic [22:0] got, exp_v;
      ew = '{W_T0, W_T1, W_T2, M_GRB | M_BA | M_YI, M_CO | M_ZI, M_ZLO | M_MARI,
             M_GRA | M_ROUT | M_MDRI, M_WR, W_T0};
      bus.ir_op    = OP_ST;
      bus.mem_done = 1'b1;
      for (int i = 0; i < 9; i++) begin
         got   = {bus.step, obs()};
         exp_v = {(i == 8) ? 4'd0 : 4'(i), ew[i]};
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL st_row%0d: got %h expected %h", i, got, exp_v);
         end
         if (i < 8) tick();
      end
   endtask

   task automatic test_nop();
      logic [4:0] ops [2];
      ops = '{OP_NOP, 5'b10101};
      bus.mem_done = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.ir_op = ops[i];
         repeat (3) tick();
         total++;
         if ({bus.step, obs()} !== {4'd3, 19'd0}) begin
            bad++;
            $display("FAIL nop_t3_%0d: got %h expected %h", i, {bus.step, obs()}, {4'd3, 19'd0});
         end
         tick();
         total++;
         if ({bus.step, obs()} !== {4'd0, W_T0}) begin
            bad++;
            $display("FAIL nop_ret_%0d: got %h expected %h", i, {bus.step, obs()}, {4'd0, W_T0});
         end
      end
   endtask

   task automatic test_halt();
      bus.ir_op    = OP_HALT;
      bus.mem_done = 1'b1;
      repeat (3) tick();
      total++;
      if ({bus.step, bus.halted, obs()} !== {4'd3, 1'b0, 19'd0}) begin
         bad++;
         $display("FAIL halt_t3: got %h expected %h", {bus.step, bus.halted, obs()},
                  {4'd3, 1'b0, 19'd0});
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if ({bus.step, bus.halted, bus.alu_op, obs()} !== {4'd15, 1'b1, 4'd0, 19'd0}) begin
            bad++;
            $display("FAIL halt_hold%0d: got %h expected %h", i,
                     {bus.step, bus.halted, bus.alu_op, obs()}, {4'd15, 1'b1, 4'd0, 19'd0});
         end
      end
      clr = 1'b1;
      #1;
      total++;
      if ({bus.step, bus.halted, bus.alu_op, obs()} !== 28'd0) begin
         bad++;
         $display("FAIL halt_clr: got %h expected 0", {bus.step, bus.halted, bus.alu_op, obs()});
      end
      clr = 1'b0;
      #1;
      total++;
      if ({bus.step, bus.halted, obs()} !== {4'd0, 1'b0, W_T0}) begin
         bad++;
         $display("FAIL halt_restart: got %h expected %h", {bus.step, bus.halted, obs()},
                  {4'd0, 1'b0, W_T0});
      end
   endtask

   task automatic test_clr_abort();
      bus.ir_op    = OP_LD;
      bus.mem_done = 1'b0;
      tick();
      total++;
      if ({bus.step, bus.read} !== {4'd1, 1'b1}) begin
         bad++;
         $display("FAIL abort_t1_read: got %h expected %h", {bus.step, bus.read}, {4'd1, 1'b1});
      end
      #2;
      clr = 1'b1;
      #1;
      total++;
      if ({bus.step, obs()} !== 23'd0) begin
         bad++;
         $display("FAIL abort_read_drop: got %h expected 0", {bus.step, obs()});
      end
      #1;
      clr = 1'b0;
      #1;
      total++;
      if ({bus.step, obs()} !== {4'd0, W_T0}) begin
         bad++;
         $display("FAIL abort_restart_t0: got %h expected %h", {bus.step, obs()}, {4'd0, W_T0});
      end
      tick();
      total++;
      if (bus.step !== 4'd1) begin
         bad++;
         $display("FAIL abort_restart_t1: got %0d expected 1", bus.step);
      end
      bus.ir_op    = OP_ST;
      bus.mem_done = 1'b1;
      repeat (6) tick();
      total++;
      if ({bus.step, obs()} !== {4'd7, M_WR}) begin
         bad++;
         $display("FAIL abort_t7_write: got %h expected %h", {bus.step, obs()}, {4'd7, M_WR});
      end
      #2;
      clr = 1'b1;
      #1;
      total++;
      if ({bus.step, obs()} !== 23'd0) begin
         bad++;
         $display("FAIL abort_write_drop: got %h expected 0", {bus.step, obs()});
      end
      #1;
      clr = 1'b0;
      #1;
   endtask

`ifdef MEM_WAIT_EN
   task automatic test_mem_wait();
      bus.ir_op    = OP_ADD;
      bus.mem_done = 1'b0;
      tick();
      total++;
      if (bus.step !== 4'd1) begin
         bad++;
         $display("FAIL wait_t0_ignore: got %0d expected 1", bus.step);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({bus.step, obs()} !== {4'd1, W_T1}) begin
            bad++;
            $display("FAIL wait_t1_hold%0d: got %h expected %h", i, {bus.step, obs()}, {4'd1, W_T1});
         end
      end
      bus.mem_done = 1'b1;
      tick();
      bus.mem_done = 1'b0;
      total++;
      if (bus.step !== 4'd2) begin
         bad++;
         $display("FAIL wait_t1_release: got %0d expected 2", bus.step);
      end
      repeat (4) tick();
      total++;
      if (bus.step !== 4'd0) begin
         bad++;
         $display("FAIL wait_exec_ignore: got %0d expected 0", bus.step);
      end
   endtask
`endif

   initial begin
      total        = 0;
      bad          = 0;
      clr          = 1'b1;
      bus.ir_op    = OP_NOP;
      bus.mem_done = 1'b0;
      test_reset();
      test_add();
      test_alu_ops();
      test_ld();
      test_st();
      test_nop();
      test_halt();
      test_clr_abort();
`ifdef MEM_WAIT_EN
      test_mem_wait();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
